pheromone_table_scheduler: RTL and testbench
============================================

# pheromone_table_scheduler

Owns the per-router pheromone table (NODES destinations × 4 neighbour ports) and shares its single write path between the five ant-agent input lanes and a periodic evaporation sweep. It sits beside the ant agent inside each router. It grants at most one reinforcement per cycle, round-robin across lanes, and sequences the evaporation sweep row by row. The route path reads the table through a combinational lookup port.

## Interface
- NODES, 16, number of destination rows (`NODES)
- PORTS, 4, neighbour ports per row (`N-1: north, east, south, west)
- DEPTH, 8, pheromone entry width in bits
- INC, 16, reinforcement step added to the chosen entry
- EVAP_INTERVAL, 1024, cycles between evaporation sweep starts (≥ NODES+1)
- EVAP_SHIFT, 3, evaporation amount is entry >> EVAP_SHIFT
- PH_MIN, 1, floor value for evaporation
- STALL_MAX, 4, maximum consecutive cycles a sweep may yield to updates
- clk  in  1  clock; one clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_upd_req  in  [0:`N-1]  reinforcement request per input lane; held until granted
- i_upd_dest  in  [0:`N-1][$clog2(NODES)-1:0]  destination row per lane
- i_upd_port  in  [0:`N-1][1:0]  neighbour port to reinforce per lane
- o_upd_gnt  out  [0:`N-1]  one-hot grant; combinational, table written at next edge
- i_rd_dest  in  $clog2(NODES)  lookup row
- o_rd_ph  out  [0:PORTS-1][DEPTH-1:0]  combinational read of row i_rd_dest
- o_evap_busy  out  1  high while the FSM is in SWEEP
- o_sweep_row  out  $clog2(NODES)  row the sweep will process next

## Operation
- Reset: every entry = 2^(DEPTH-1) (128); o_upd_gnt=0; rr pointer=0; interval counter=0; FSM=IDLE; o_evap_busy=0; o_sweep_row=0; stall counter=0; pending flag=0.
- Arbitration: the requesting lane nearest at or above the rr pointer wins, modulo `N. After a grant, pointer = granted+1 mod `N. The pointer holds when nothing is granted.
- Reinforcement: entry[dest][port] = min(entry+INC, 2^DEPTH-1), computed at DEPTH+1 bits. Other entries in the row are unchanged.
- Interval counter: free-running 0..EVAP_INTERVAL-1. At terminal count, pending is set.
- FSM IDLE: pending=1 → SWEEP, pending cleared, row=0.
- FSM SWEEP: the sweep "takes" a cycle when there are no update requests, or when the stall counter equals STALL_MAX. Updates take the cycle otherwise.
- Sweep take: all PORTS entries of the current row get e' = max(e - (e>>EVAP_SHIFT), PH_MIN). o_upd_gnt=0 in that cycle. Stall counter=0. Row increments.
- Update take: the stall counter increments and the row holds.
- After row NODES-1 is taken, the FSM returns to IDLE.
- Terminal count during SWEEP sets pending, so a new sweep starts in the first IDLE cycle.
- Updates never write the row being swept in the same cycle, because grant and sweep are mutually exclusive per cycle.

## Timing
- Grant to table update: write at the next rising edge. o_rd_ph reflects the new value one cycle after the grant.
- Sweep duration: NODES cycles minimum. Worst case is NODES×(STALL_MAX+1) cycles.
- Single request into an idle table: granted in the same cycle.
- Reset asserted mid-sweep: the table reinitialises immediately and the FSM returns to IDLE. No partial row survives.
- Reset released: the first sweep starts EVAP_INTERVAL cycles later.

## Configuration
- PH_EVAP_EN defined: interval counter, SWEEP FSM and stall counter are compiled in, as described.
- PH_EVAP_EN undefined: no evaporation logic. Entries only increase and saturate. o_evap_busy=0 and o_sweep_row=0 permanently. Updates are always granted when requested.

## Test plan
- Reset value: after reset, any i_rd_dest → o_rd_ph all entries = 128, o_evap_busy=0.
- Arbitration: lanes 0,2,4 request continuously (dest 3, port 1).
  - Grants go 0,2,4,0.
  - Entry[3][1] goes 128→144→160→176→192 on successive cycles.
- Saturation: 8 grants of INC=16 to entry[5][2] from 128 → value 255, not 0.
- Evaporation (PH_EVAP_EN): idle table, entry[0][0]=200.
  - At cycle EVAP_INTERVAL, o_evap_busy rises.
  - One cycle later entry[0][0]=175 (200-25), and 128 entries become 112.
  - Busy falls after 16 cycles.
  - Entry at 1 stays 1.
- Stall limit: lane 1 requests continuously during SWEEP.
  - Lane 1 is granted 4 cycles, then the sweep takes 1 cycle with o_upd_gnt=0. This pattern repeats.
  - Sweep completes in 80 cycles.
- Reset mid-sweep at row 7 → all entries 128, o_sweep_row=0, o_evap_busy=0 in the reset cycle.

Source files
------------

// File: rtl/pheromone_table_scheduler_if.sv
// Lane/lookup bundle between the ant agent, route path and the pheromone table.
// Lane arrays run ascending: index 0 is lane 0.
interface pheromone_table_scheduler_if #(
  parameter int NODES = 16,
  parameter int PORTS = 4,
  parameter int DEPTH = 8,
  parameter int LANES = 5
);
  localparam int DW = $clog2(NODES);
  localparam int PW = $clog2(PORTS);

  logic [0:LANES-1]          i_upd_req;
  logic [0:LANES-1][DW-1:0]  i_upd_dest;
  logic [0:LANES-1][PW-1:0]  i_upd_port;
  logic [0:LANES-1]          o_upd_gnt;
  logic [DW-1:0]             i_rd_dest;
  logic [0:PORTS-1][DEPTH-1:0] o_rd_ph;
  logic                      o_evap_busy;
  logic [DW-1:0]             o_sweep_row;

  modport master (
    output i_upd_req, i_upd_dest, i_upd_port, i_rd_dest,
    input  o_upd_gnt, o_rd_ph, o_evap_busy, o_sweep_row
  );

  modport slave (
    input  i_upd_req, i_upd_dest, i_upd_port, i_rd_dest,
    output o_upd_gnt, o_rd_ph, o_evap_busy, o_sweep_row
  );
endinterface

// File: rtl/pheromone_table_scheduler.sv
// Pheromone table with round-robin lane writes and an optional evaporation
// sweep compiled in by defining PH_EVAP_EN.
module pheromone_table_scheduler #(
  parameter int NODES         = 16,
  parameter int PORTS         = 4,
  parameter int DEPTH         = 8,
  parameter int INC           = 16,
  parameter int EVAP_INTERVAL = 1024,
  parameter int EVAP_SHIFT    = 3,
  parameter int PH_MIN        = 1,
  parameter int STALL_MAX     = 4,
  parameter int LANES         = 5
) (
  input logic clk,
  input logic reset_n,
  pheromone_table_scheduler_if.slave bus
);
  localparam int DW = $clog2(NODES);
  localparam int PW = $clog2(PORTS);
  localparam int LW = $clog2(LANES);
  localparam logic [DEPTH-1:0] PH_INIT = {1'b1, {(DEPTH-1){1'b0}}};

  logic [DEPTH-1:0] tbl [NODES][PORTS];
  logic [LW-1:0]    rr;
  logic [LW-1:0]    win;
  logic             any_req;
  logic             upd_en;
  logic             take;
  logic [DW-1:0]    row;
  logic [DW-1:0]    wr_dest;
  logic [PW-1:0]    wr_port;
  logic [DEPTH:0]   sum;
  logic [DEPTH-1:0] sat_val;
  logic [0:LANES-1] gnt;

  function automatic logic [LW-1:0] lane_at(logic [LW-1:0] base, int off);
    int s;
    s = int'(base) + off;
    if (s >= LANES) s = s - LANES;
    return LW'(s);
  endfunction

  function automatic logic [DEPTH-1:0] evap(logic [DEPTH-1:0] e);
    logic [DEPTH-1:0] d;
    d = e - (e >> EVAP_SHIFT);
    return (d < DEPTH'(PH_MIN)) ? DEPTH'(PH_MIN) : d;
  endfunction

  // First requester at or after the pointer, wrapping over the lanes
  always_comb begin
    win     = rr;
    any_req = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (!any_req && bus.i_upd_req[lane_at(rr, i)]) begin
        win     = lane_at(rr, i);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    wr_dest = bus.i_upd_dest[win];
    wr_port = bus.i_upd_port[win];
    sum     = {1'b0, tbl[wr_dest][wr_port]} + (DEPTH+1)'(INC);
    sat_val = sum[DEPTH] ? '1 : sum[DEPTH-1:0];
  end

  always_comb begin
    gnt = '0;
    if (upd_en) gnt[win] = 1'b1;
  end

  assign bus.o_upd_gnt = gnt;

  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      bus.o_rd_ph[p] = tbl[bus.i_rd_dest][p];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr <= '0;
    end else if (upd_en) begin
      rr <= (win == LW'(LANES-1)) ? '0 : win + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < NODES; n++) begin
        for (int p = 0; p < PORTS; p++) begin
          tbl[n][p] <= PH_INIT;
        end
      end
    end else if (upd_en) begin
      tbl[wr_dest][wr_port] <= sat_val;
    end else if (take) begin
      for (int p = 0; p < PORTS; p++) begin
        tbl[row][p] <= evap(tbl[row][p]);
      end
    end
  end

`ifdef PH_EVAP_EN
  localparam int CW = $clog2(EVAP_INTERVAL);
  localparam int SW = $clog2(STALL_MAX+1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          tc;
  logic          pending, pending_nx;
  logic [DW-1:0] row_nx;
  logic [SW-1:0] stall, stall_nx;

  assign tc = (cnt == CW'(EVAP_INTERVAL-1));

  // Grant and sweep are exclusive per cycle, so a row is never
  // reinforced and evaporated on the same edge
  always_comb begin
    state_nx   = state;
    pending_nx = pending | tc;
    row_nx     = row;
    stall_nx   = stall;
    take       = 1'b0;
    upd_en     = any_req;
    unique case (state)
      IDLE: begin
        if (pending || tc) begin
          state_nx   = SWEEP;
          pending_nx = 1'b0;
          row_nx     = '0;
          stall_nx   = '0;
        end
      end
      SWEEP: begin
        take   = !any_req || (stall == SW'(STALL_MAX));
        upd_en = any_req && !take;
        if (take) begin
          stall_nx = '0;
          if (row == DW'(NODES-1)) begin
            state_nx = IDLE;
            row_nx   = '0;
          end else begin
            row_nx = row + 1'b1;
          end
        end else begin
          stall_nx = stall + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      pending <= 1'b0;
      row     <= '0;
      stall   <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= tc ? '0 : cnt + 1'b1;
      pending <= pending_nx;
      row     <= row_nx;
      stall   <= stall_nx;
    end
  end

  assign bus.o_evap_busy = (state == SWEEP);
  assign bus.o_sweep_row = row;
`else
  logic [31:0] unused_cfg;

  assign unused_cfg      = 32'(EVAP_INTERVAL) ^ 32'(STALL_MAX);
  assign upd_en          = any_req;
  assign take            = 1'b0;
  assign row             = '0;
  assign bus.o_evap_busy = 1'b0;
  assign bus.o_sweep_row = '0;
`endif

endmodule

// File: tb/tb_pheromone_table_scheduler.sv
// Directed vector bench for pheromone_table_scheduler; evaporation
// sequences run only when PH_EVAP_EN is defined.
module tb_pheromone_table_scheduler;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   edges = 0;

  always #5 clk = ~clk;

  pheromone_table_scheduler_if bus ();

  pheromone_table_scheduler dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [0:4] req;
    logic [3:0] dest;
    logic [1:0] port;
    logic [0:4] gnt;
    logic [3:0] row;
    logic [1:0] col;
    logic [7:0] val;
  } vec_t;

  vec_t vt [18];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic tick_to(int target);
    while (edges < target) tick();
  endtask

  task automatic drive(logic [0:4] req, logic [3:0] dest, logic [1:0] port);
    for (int i = 0; i < 5; i++) begin
      bus.i_upd_req[i]  = req[i];
      bus.i_upd_dest[i] = req[i] ? dest : ~dest;
      bus.i_upd_port[i] = req[i] ? port : ~port;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    edges = 0;
  endtask

  initial begin
    vt[0]  = '{5'b10101, 4'd3, 2'd1, 5'b10000, 4'd3, 2'd1, 8'd144};
    vt[1]  = '{5'b10101, 4'd3, 2'd1, 5'b00100, 4'd3, 2'd1, 8'd160};
    vt[2]  = '{5'b10101, 4'd3, 2'd1, 5'b00001, 4'd3, 2'd1, 8'd176};
    vt[3]  = '{5'b10101, 4'd3, 2'd1, 5'b10000, 4'd3, 2'd1, 8'd192};
    vt[4]  = '{5'b00000, 4'd3, 2'd1, 5'b00000, 4'd3, 2'd1, 8'd192};
    vt[5]  = '{5'b10000, 4'd5, 2'd2, 5'b10000, 4'd5, 2'd2, 8'd144};
    vt[6]  = '{5'b10000, 4'd5, 2'd2, 5'b10000, 4'd5, 2'd2, 8'd160};
    vt[7]  = '{5'b10000, 4'd5, 2'd2, 5'b10000, 4'd5, 2'd2, 8'd176};
    vt[8]  = '{5'b10000, 4'd5, 2'd2, 5'b10000, 4'd5, 2'd2, 8'd192};
    vt[9]  = '{5'b10000, 4'd5, 2'd2, 5'b10000, 4'd5, 2'd2, 8'd208};
    vt[10] = '{5'b10000, 4'd5, 2'd2, 5'b10000, 4'd5, 2'd2, 8'd224};
    vt[11] = '{5'b10000, 4'd5, 2'd2, 5'b10000, 4'd5, 2'd2, 8'd240};
    vt[12] = '{5'b10000, 4'd5, 2'd2, 5'b10000, 4'd5, 2'd2, 8'd255};
    vt[13] = '{5'b10000, 4'd5, 2'd2, 5'b10000, 4'd5, 2'd2, 8'd255};
    vt[14] = '{5'b11111, 4'd7, 2'd0, 5'b01000, 4'd7, 2'd0, 8'd144};
    vt[15] = '{5'b11001, 4'd7, 2'd0, 5'b00001, 4'd7, 2'd0, 8'd160};
    vt[16] = '{5'b01000, 4'd7, 2'd0, 5'b01000, 4'd7, 2'd0, 8'd176};
    vt[17] = '{5'b00000, 4'd7, 2'd0, 5'b00000, 4'd7, 2'd1, 8'd128};

    drive(5'b00000, 4'd0, 2'd0);
    bus.i_rd_dest = '0;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_entry", 32'(bus.o_rd_ph[0]), 128);
    do_reset();

    for (int r = 0; r < 16; r++) begin
      bus.i_rd_dest = 4'(r);
      #1;
      check($sformatf("reset_row%0d", r),
            {bus.o_rd_ph[0], bus.o_rd_ph[1], bus.o_rd_ph[2], bus.o_rd_ph[3]},
            32'h80808080);
    end
    check("reset_busy", 32'(bus.o_evap_busy), 0);
    check("reset_sweep_row", 32'(bus.o_sweep_row), 0);
    check("reset_gnt", 32'(bus.o_upd_gnt), 0);

    for (int k = 0; k < 18; k++) begin
      drive(vt[k].req, vt[k].dest, vt[k].port);
      bus.i_rd_dest = vt[k].row;
      #1;
      check($sformatf("gnt_v%0d", k), 32'(bus.o_upd_gnt), 32'(vt[k].gnt));
      tick();
      check($sformatf("val_v%0d", k), 32'(bus.o_rd_ph[vt[k].col]), 32'(vt[k].val));
    end

`ifndef PH_EVAP_EN
    drive(5'b00000, 4'd0, 2'd0);
    bus.i_rd_dest = 4'd3;
    tick_to(1200);
    check("no_evap_entry", 32'(bus.o_rd_ph[1]), 192);
    check("no_evap_busy", 32'(bus.o_evap_busy), 0);
    check("no_evap_row", 32'(bus.o_sweep_row), 0);
`else
    do_reset();
    drive(5'b10000, 4'd0, 2'd0);
    tick_to(5);
    drive(5'b00000, 4'd0, 2'd0);
    bus.i_rd_dest = 4'd0;
    #1;
    check("pre_evap_val", 32'(bus.o_rd_ph[0]), 208);
    tick_to(1023);
    check("busy_before_interval", 32'(bus.o_evap_busy), 0);
    tick();
    check("busy_at_interval", 32'(bus.o_evap_busy), 1);
    check("sweep_row_start", 32'(bus.o_sweep_row), 0);
    tick();
    check("evap_208", 32'(bus.o_rd_ph[0]), 182);
    check("evap_128", 32'(bus.o_rd_ph[1]), 112);
    check("sweep_row_next", 32'(bus.o_sweep_row), 1);
    tick_to(1039);
    check("busy_last_row", 32'(bus.o_evap_busy), 1);
    tick();
    check("busy_after_sweep", 32'(bus.o_evap_busy), 0);
    bus.i_rd_dest = 4'd15;
    #1;
    check("evap_last_row", 32'(bus.o_rd_ph[3]), 112);

    tick_to(2048);
    check("busy_second_sweep", 32'(bus.o_evap_busy), 1);
    drive(5'b01000, 4'd9, 2'd3);
    for (int c = 0; c < 80; c++) begin
      #1;
      check($sformatf("stall_gnt_c%0d", c), 32'(bus.o_upd_gnt),
            (c % 5 == 4) ? 32'h0 : 32'h8);
      tick();
    end
    check("stall_sweep_done", 32'(bus.o_evap_busy), 0);
    drive(5'b00000, 4'd0, 2'd0);

    tick_to(3072 + 7);
    check("mid_sweep_row", 32'(bus.o_sweep_row), 7);
    bus.i_rd_dest = 4'd3;
    reset_n = 1'b0;
    #1;
    check("mid_reset_busy", 32'(bus.o_evap_busy), 0);
    check("mid_reset_row", 32'(bus.o_sweep_row), 0);
    check("mid_reset_entry", 32'(bus.o_rd_ph[2]), 128);
    #20;
    reset_n = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got %0d edges expected completion", edges);
    $fatal(1, "timeout");
  end
endmodule
